// File: rtl/fp_div_issuer.sv
// Requester front-end for a shared FP divider with no backpressure: admits a request
// only when a result slot is reserved, checks in-order tag return, buffers results.
module fp_div_issuer #(
    parameter int unsigned FP_WIDTH   = 32,
    parameter int unsigned TAG_WIDTH  = 5,
    parameter int unsigned RND_WIDTH  = 3,
    parameter int unsigned STAT_WIDTH = 8,
    parameter int unsigned RES_DEPTH  = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  ReqValid_i,
    output logic                  ReqReady_o,
    input  logic [FP_WIDTH-1:0]   ReqOpA_i,
    input  logic [FP_WIDTH-1:0]   ReqOpB_i,
    input  logic [RND_WIDTH-1:0]  ReqRnd_i,
    input  logic [TAG_WIDTH-1:0]  ReqId_i,
    output logic                  En_o,
    output logic [FP_WIDTH-1:0]   OpA_o,
    output logic [FP_WIDTH-1:0]   OpB_o,
    output logic [TAG_WIDTH-1:0]  Tag_o,
    output logic [RND_WIDTH-1:0]  Rnd_o,
    input  logic                  Ready_i,
    input  logic                  Valid_i,
    input  logic [FP_WIDTH-1:0]   Res_i,
    input  logic [STAT_WIDTH-1:0] Status_i,
    input  logic [TAG_WIDTH-1:0]  Tag_i,
    output logic                  RspValid_o,
    input  logic                  RspReady_i,
    output logic [FP_WIDTH-1:0]   RspRes_o,
    output logic [STAT_WIDTH-1:0] RspStatus_o,
    output logic [TAG_WIDTH-1:0]  RspId_o,
    output logic                  Busy_o,
    output logic                  TagErr_o
);
    localparam int unsigned PTR_W = $clog2(RES_DEPTH);
    localparam int unsigned CNT_W = $clog2(RES_DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(RES_DEPTH);

    logic [CNT_W-1:0]      occ_q, occ_d;
    logic [TAG_WIDTH-1:0]  tq_mem_q [RES_DEPTH];
    logic [TAG_WIDTH-1:0]  tq_mem_d [RES_DEPTH];
    logic [PTR_W-1:0]      tq_wr_q, tq_wr_d, tq_rd_q, tq_rd_d;
    logic [CNT_W-1:0]      tq_cnt_q, tq_cnt_d;
    logic [FP_WIDTH-1:0]   res_mem_q [RES_DEPTH];
    logic [FP_WIDTH-1:0]   res_mem_d [RES_DEPTH];
    logic [STAT_WIDTH-1:0] stat_mem_q [RES_DEPTH];
    logic [STAT_WIDTH-1:0] stat_mem_d [RES_DEPTH];
    logic [TAG_WIDTH-1:0]  id_mem_q [RES_DEPTH];
    logic [TAG_WIDTH-1:0]  id_mem_d [RES_DEPTH];
    logic [PTR_W-1:0]      rf_wr_q, rf_wr_d, rf_rd_q, rf_rd_d;
    logic [CNT_W-1:0]      rf_cnt_q, rf_cnt_d;
    logic                  tag_err_q, tag_err_d;

    logic req_ready, accept, tq_empty, rf_empty, rf_full, rsp_pop, ret_pop, rf_write;

    // Credit check and handshake decode
    always_comb begin
        req_ready = !rst_i && Ready_i && (occ_q < DEPTH_C);
        accept    = ReqValid_i && req_ready;
        tq_empty  = (tq_cnt_q == '0);
        rf_empty  = (rf_cnt_q == '0);
        rf_full   = (rf_cnt_q == DEPTH_C);
        rsp_pop   = !rst_i && !rf_empty && RspReady_i;
        ret_pop   = Valid_i && !tq_empty;
        rf_write  = ret_pop && !rf_full;
    end

    always_comb begin
        occ_d      = occ_q;
        tq_mem_d   = tq_mem_q;
        tq_wr_d    = tq_wr_q;
        tq_rd_d    = tq_rd_q;
        tq_cnt_d   = tq_cnt_q;
        res_mem_d  = res_mem_q;
        stat_mem_d = stat_mem_q;
        id_mem_d   = id_mem_q;
        rf_wr_d    = rf_wr_q;
        rf_rd_d    = rf_rd_q;
        rf_cnt_d   = rf_cnt_q;
        tag_err_d  = tag_err_q;

        if (accept && !rsp_pop) begin
            occ_d = occ_q + CNT_W'(1);
        end else if (!accept && rsp_pop) begin
            occ_d = occ_q - CNT_W'(1);
        end

        if (accept) begin
            tq_mem_d[tq_wr_q] = ReqId_i;
            tq_wr_d           = tq_wr_q + PTR_W'(1);
        end
        if (ret_pop) begin
            tq_rd_d = tq_rd_q + PTR_W'(1);
        end
        tq_cnt_d = tq_cnt_q + CNT_W'(accept) - CNT_W'(ret_pop);

        // Mismatched tags are still delivered; only an empty queue drops the result
        if (rf_write) begin
            res_mem_d[rf_wr_q]  = Res_i;
            stat_mem_d[rf_wr_q] = Status_i;
            id_mem_d[rf_wr_q]   = Tag_i;
            rf_wr_d             = rf_wr_q + PTR_W'(1);
        end
        if (rsp_pop) begin
            rf_rd_d = rf_rd_q + PTR_W'(1);
        end
        rf_cnt_d = rf_cnt_q + CNT_W'(rf_write) - CNT_W'(rsp_pop);

        if (Valid_i && (tq_empty || (tq_mem_q[tq_rd_q] != Tag_i) || rf_full)) begin
            tag_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            occ_q     <= '0;
            tq_wr_q   <= '0;
            tq_rd_q   <= '0;
            tq_cnt_q  <= '0;
            rf_wr_q   <= '0;
            rf_rd_q   <= '0;
            rf_cnt_q  <= '0;
            tag_err_q <= 1'b0;
        end else begin
            occ_q     <= occ_d;
            tq_wr_q   <= tq_wr_d;
            tq_rd_q   <= tq_rd_d;
            tq_cnt_q  <= tq_cnt_d;
            rf_wr_q   <= rf_wr_d;
            rf_rd_q   <= rf_rd_d;
            rf_cnt_q  <= rf_cnt_d;
            tag_err_q <= tag_err_d;
        end
    end

    // Storage arrays carry no reset; validity is tracked by the counters above
    always_ff @(posedge clk_i) begin
        tq_mem_q   <= tq_mem_d;
        res_mem_q  <= res_mem_d;
        stat_mem_q <= stat_mem_d;
        id_mem_q   <= id_mem_d;
    end

    assign ReqReady_o  = req_ready;
    assign En_o        = accept;
    assign OpA_o       = accept ? ReqOpA_i : '0;
    assign OpB_o       = accept ? ReqOpB_i : '0;
    assign Tag_o       = ReqId_i;
    assign Rnd_o       = ReqRnd_i;
    assign RspValid_o  = !rst_i && !rf_empty;
    assign RspRes_o    = RspValid_o ? res_mem_q[rf_rd_q] : '0;
    assign RspStatus_o = RspValid_o ? stat_mem_q[rf_rd_q] : '0;
    assign RspId_o     = RspValid_o ? id_mem_q[rf_rd_q] : '0;
    assign Busy_o      = !rst_i && (occ_q != '0);
    assign TagErr_o    = !rst_i && tag_err_q;

endmodule

// File: tb/tb_fp_div_issuer.sv
// Bench for fp_div_issuer: fixed-latency divider model plus a queue-based reference
// of credits, in-flight tags and the response FIFO, checked every cycle.
module tb_fp_div_issuer;
    localparam int unsigned FPW = 32, TW = 5, RW = 3, SW = 8, DEPTH = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_i, ReqValid_i, ReqReady_o, En_o, Ready_i, Valid_i;
    logic RspValid_o, RspReady_i, Busy_o, TagErr_o;
    logic [FPW-1:0] ReqOpA_i, ReqOpB_i, OpA_o, OpB_o, Res_i, RspRes_o;
    logic [RW-1:0]  ReqRnd_i, Rnd_o;
    logic [TW-1:0]  ReqId_i, Tag_o, Tag_i, RspId_o;
    logic [SW-1:0]  Status_i, RspStatus_o;

    fp_div_issuer #(.FP_WIDTH(FPW), .TAG_WIDTH(TW), .RND_WIDTH(RW),
                    .STAT_WIDTH(SW), .RES_DEPTH(DEPTH)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .ReqValid_i(ReqValid_i), .ReqReady_o(ReqReady_o), .ReqOpA_i(ReqOpA_i),
        .ReqOpB_i(ReqOpB_i), .ReqRnd_i(ReqRnd_i), .ReqId_i(ReqId_i),
        .En_o(En_o), .OpA_o(OpA_o), .OpB_o(OpB_o), .Tag_o(Tag_o), .Rnd_o(Rnd_o),
        .Ready_i(Ready_i), .Valid_i(Valid_i), .Res_i(Res_i), .Status_i(Status_i),
        .Tag_i(Tag_i), .RspValid_o(RspValid_o), .RspReady_i(RspReady_i),
        .RspRes_o(RspRes_o), .RspStatus_o(RspStatus_o), .RspId_o(RspId_o),
        .Busy_o(Busy_o), .TagErr_o(TagErr_o)
    );

    typedef struct packed {
        logic [FPW-1:0] res;
        logic [SW-1:0]  stat;
        logic [TW-1:0]  id;
    } ent_t;

    typedef struct packed {
        int unsigned    due;
        logic [TW-1:0]  tag;
        logic [FPW-1:0] res;
        logic [SW-1:0]  stat;
    } pend_t;

    ent_t          m_fifo[$];
    logic [TW-1:0] m_tags[$];
    pend_t         pend[$];
    int            m_occ;
    bit            m_err;
    int unsigned   cyc, lat;
    int            n_cmp, n_fail;

    logic          s_ready, s_en, s_rv, s_busy, s_err;
    logic [FPW-1:0] s_res, s_opa;
    logic [TW-1:0] s_id;
    int unsigned   s_cyc;

    function automatic logic [FPW-1:0] fdiv(input logic [FPW-1:0] a, input logic [FPW-1:0] b);
        if (a == 32'h40C0_0000 && b == 32'h4000_0000) return 32'h4040_0000;
        return (a * 32'd2654435761) ^ {b[15:0], b[31:16]};
    endfunction

    function automatic logic [SW-1:0] fstat(input logic [FPW-1:0] a, input logic [FPW-1:0] b);
        return a[7:0] ^ b[15:8];
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock: compare at negedge, advance the reference at posedge, then drive divider returns
    task automatic tick();
        bit e_ready, e_acc, e_rv, pop;
        ent_t h, ne;
        pend_t p;
        @(negedge clk);
        e_ready = !rst_i && Ready_i && (m_occ < DEPTH);
        e_acc   = ReqValid_i && e_ready;
        e_rv    = !rst_i && (m_fifo.size() > 0);
        check("req_ready", 64'(ReqReady_o), 64'(e_ready));
        check("en", 64'(En_o), 64'(e_acc));
        check("op_a", 64'(OpA_o), e_acc ? 64'(ReqOpA_i) : 64'h0);
        check("op_b", 64'(OpB_o), e_acc ? 64'(ReqOpB_i) : 64'h0);
        check("tag_o", 64'(Tag_o), 64'(ReqId_i));
        check("rnd_o", 64'(Rnd_o), 64'(ReqRnd_i));
        check("rsp_valid", 64'(RspValid_o), 64'(e_rv));
        check("busy", 64'(Busy_o), 64'(!rst_i && m_occ != 0));
        check("tag_err", 64'(TagErr_o), 64'(!rst_i && m_err));
        if (e_rv) begin
            h = m_fifo[0];
            check("rsp_res", 64'(RspRes_o), 64'(h.res));
            check("rsp_status", 64'(RspStatus_o), 64'(h.stat));
            check("rsp_id", 64'(RspId_o), 64'(h.id));
        end
        s_ready = ReqReady_o; s_en = En_o; s_rv = RspValid_o; s_busy = Busy_o;
        s_err = TagErr_o; s_res = RspRes_o; s_id = RspId_o; s_opa = OpA_o; s_cyc = cyc;
        @(posedge clk);
        if (rst_i) begin
            m_fifo.delete();
            m_tags.delete();
            m_occ = 0;
            m_err = 1'b0;
        end else begin
            pop = e_rv && RspReady_i;
            if (Valid_i) begin
                if (m_tags.size() == 0) begin
                    m_err = 1'b1;
                end else begin
                    if (m_tags[0] !== Tag_i) m_err = 1'b1;
                    void'(m_tags.pop_front());
                    if (m_fifo.size() >= DEPTH) begin
                        m_err = 1'b1;
                    end else begin
                        ne.res = Res_i; ne.stat = Status_i; ne.id = Tag_i;
                        m_fifo.push_back(ne);
                    end
                end
            end
            if (pop) begin
                void'(m_fifo.pop_front());
                m_occ--;
            end
            if (e_acc) begin
                m_occ++;
                m_tags.push_back(ReqId_i);
                p.due = cyc + lat; p.tag = ReqId_i;
                p.res = fdiv(ReqOpA_i, ReqOpB_i); p.stat = fstat(ReqOpA_i, ReqOpB_i);
                pend.push_back(p);
            end
        end
        #1;
        cyc++;
        Valid_i  = 1'b0;
        Tag_i    = TW'($urandom);
        Res_i    = $urandom;
        Status_i = SW'($urandom);
        if (pend.size() > 0 && pend[0].due == cyc) begin
            p = pend.pop_front();
            Valid_i = 1'b1; Tag_i = p.tag; Res_i = p.res; Status_i = p.stat;
        end
    endtask

    task automatic set_req(input logic [TW-1:0] id, input logic [FPW-1:0] a, input logic [FPW-1:0] b);
        ReqValid_i = 1'b1; ReqId_i = id; ReqOpA_i = a; ReqOpB_i = b; ReqRnd_i = RW'($urandom);
    endtask

    task automatic idle();
        ReqValid_i = 1'b0; ReqOpA_i = $urandom; ReqOpB_i = $urandom;
        ReqId_i = TW'($urandom); ReqRnd_i = RW'($urandom);
    endtask

    task automatic do_reset(input int n);
        rst_i = 1'b1;
        repeat (n) tick();
        rst_i = 1'b0;
    endtask

    task automatic drain();
        idle();
        RspReady_i = 1'b1; Ready_i = 1'b1;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (m_occ == 0 && pend.size() == 0 && m_fifo.size() == 0) break;
        end
        tick();
        check("drain_idle", 64'(s_busy), 64'h0);
    endtask

    initial begin
        logic [TW-1:0] got[$];
        int unsigned t0;
        bit found;
        n_cmp = 0; n_fail = 0; cyc = 0; lat = 2; m_occ = 0; m_err = 0;
        rst_i = 1'b1; Ready_i = 1'b1; RspReady_i = 1'b0;
        Valid_i = 1'b0; Tag_i = '0; Res_i = '0; Status_i = '0;
        set_req(5'd1, 32'h1234_5678, 32'h9ABC_DEF0);

        // Reset with a pending request must hold every handshake low
        do_reset(2);
        check("rst_ready", 64'(s_ready), 64'h0);
        check("rst_en", 64'(s_en), 64'h0);
        check("rst_opa", 64'(s_opa), 64'h0);
        check("rst_rv", 64'(s_rv), 64'h0);
        idle();
        tick();
        check("post_rst_busy", 64'(s_busy), 64'h0);
        check("post_rst_ready", 64'(s_ready), 64'h1);

        // Single op: 6.0 / 2.0, latency 2 -> response three cycles after accept
        RspReady_i = 1'b1;
        set_req(5'd3, 32'h40C0_0000, 32'h4000_0000);
        t0 = cyc;
        tick();
        check("single_en", 64'(s_en), 64'h1);
        idle();
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            tick();
            if (s_rv) found = 1'b1;
        end
        check("single_seen", 64'(found), 64'h1);
        check("single_lat", 64'(s_cyc - t0), 64'd3);
        check("single_res", 64'(s_res), 64'h4040_0000);
        check("single_id", 64'(s_id), 64'd3);
        tick();
        check("single_busy", 64'(s_busy), 64'h0);

        // Fill with response side stalled, then free one credit
        RspReady_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            set_req(TW'(i), $urandom, $urandom);
            tick();
            check("fill_acc", 64'(s_en), 64'h1);
        end
        set_req(5'd4, $urandom, $urandom);
        repeat (4) tick();
        check("fill_full", 64'(s_ready), 64'h0);
        RspReady_i = 1'b1;
        tick();
        check("pop_cycle_ready", 64'(s_ready), 64'h0);
        check("pop_cycle_id", 64'(s_id), 64'd0);
        RspReady_i = 1'b0;
        tick();
        check("credit_ready", 64'(s_ready), 64'h1);
        check("credit_en", 64'(s_en), 64'h1);
        idle();
        RspReady_i = 1'b1;
        got.delete();
        for (int i = 0; i < 20; i++) begin
            tick();
            if (s_rv) got.push_back(s_id);
        end
        check("order_count", 64'(got.size()), 64'd4);
        for (int i = 0; i < got.size(); i++) check("order_id", 64'(got[i]), 64'(i + 1));

        // Full credits, then accept and pop in the same cycle repeatedly
        RspReady_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            set_req(TW'(8 + i), $urandom, $urandom);
            tick();
        end
        idle();
        repeat (3) tick();
        RspReady_i = 1'b1;
        set_req(5'd12, $urandom, $urandom);
        tick();
        check("sim_full_ready", 64'(s_ready), 64'h0);
        for (int k = 0; k < 4; k++) begin
            set_req(TW'(12 + k), $urandom, $urandom);
            tick();
            check("sim_acc_pop", 64'(s_ready), 64'h1);
        end
        drain();

        // Tag mismatch: divider returns 7 while head is 2
        set_req(5'd2, $urandom, $urandom);
        tick();
        idle();
        tick();
        check("mm_valid_due", 64'(Valid_i), 64'h1);
        Tag_i = 5'd7;
        tick();
        check("mm_err_same", 64'(s_err), 64'h0);
        tick();
        check("mm_err_next", 64'(s_err), 64'h1);
        check("mm_delivered", 64'(s_rv), 64'h1);
        check("mm_id", 64'(s_id), 64'd7);
        tick();
        check("mm_sticky", 64'(s_err), 64'h1);

        // Spurious return with nothing outstanding
        do_reset(1);
        tick();
        check("spur_clean", 64'(s_err), 64'h0);
        Valid_i = 1'b1; Tag_i = 5'd5;
        tick();
        tick();
        check("spur_rv", 64'(s_rv), 64'h0);
        check("spur_err", 64'(s_err), 64'h1);

        // Reset with three ops in flight, then late returns
        do_reset(1);
        lat = 4;
        RspReady_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_req(TW'(20 + i), $urandom, $urandom);
            tick();
        end
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        check("mid_rst_ready", 64'(s_ready), 64'h0);
        check("mid_rst_en", 64'(s_en), 64'h0);
        check("mid_rst_busy", 64'(s_busy), 64'h0);
        check("mid_rst_rv", 64'(s_rv), 64'h0);
        idle();
        repeat (5) tick();
        check("late_err", 64'(s_err), 64'h1);
        check("late_rv", 64'(s_rv), 64'h0);
        lat = 2;
        do_reset(1);
        RspReady_i = 1'b1;
        set_req(5'd9, 32'h40C0_0000, 32'h4000_0000);
        tick();
        idle();
        got.delete();
        for (int i = 0; i < 6; i++) begin
            tick();
            if (s_rv) got.push_back(s_id);
        end
        check("recover_count", 64'(got.size()), 64'd1);
        if (got.size() > 0) check("recover_id", 64'(got[0]), 64'd9);
        check("recover_err", 64'(s_err), 64'h0);

        // Randomised traffic over several divider latencies
        for (int ph = 0; ph < 4; ph++) begin
            drain();
            lat = 1 + ($urandom % 4);
            for (int i = 0; i < 200; i++) begin
                ReqValid_i = ($urandom % 4) != 0;
                ReqOpA_i = $urandom; ReqOpB_i = $urandom;
                ReqId_i = TW'($urandom); ReqRnd_i = RW'($urandom);
                Ready_i = ($urandom % 8) != 0;
                RspReady_i = ($urandom % 3) != 0;
                tick();
            end
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
